intr_apb_master: RTL and testbench

INTR_APB_MASTER -- requirements
Module: intr_apb_master

---
 rtl/intr_apb_master.sv | 171 +++++++++++++++++
 tb/tb_intr_apb_master.sv | 302 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/intr_apb_master.sv
// ---------------------------------------------------------------------------
// intr_apb_master
// Converts single local read/write commands into APB transfers towards the
// interrupt-priority register file, with a bounded wait on pready_i.
//
// Parameters
//   NUM_INTR : number of priority registers on the peripheral
//   WIDTH    : APB address/data width (defaults to $clog2(NUM_INTR))
//   TIMEOUT  : max ACCESS cycles waited for pready_i (1..255)
//
// Ports
//   pclk_i, prst_i             clock, async active-high reset
//   cmd_valid_i / cmd_ready_o  command handshake (accepted only in IDLE)
//   cmd_write_i, cmd_addr_i, cmd_wdata_i   command payload
//   rsp_valid_o                one-cycle response pulse
//   rsp_rdata_o, rsp_err_o     read data / timeout flag, held until next rsp
//   paddr_o, pwdata_o, pwrite_o, psel_o, penable_o   APB request
//   prdata_i, pready_i         APB completion
// ---------------------------------------------------------------------------
module intr_apb_master #(
    parameter int unsigned NUM_INTR = 16,
    parameter int unsigned WIDTH    = $clog2(NUM_INTR),
    parameter int unsigned TIMEOUT  = 15
) (
    input  logic             pclk_i,
    input  logic             prst_i,
    input  logic             cmd_valid_i,
    output logic             cmd_ready_o,
    input  logic             cmd_write_i,
    input  logic [WIDTH-1:0] cmd_addr_i,
    input  logic [WIDTH-1:0] cmd_wdata_i,
    output logic             rsp_valid_o,
    output logic [WIDTH-1:0] rsp_rdata_o,
    output logic             rsp_err_o,
    output logic [WIDTH-1:0] paddr_o,
    output logic [WIDTH-1:0] pwdata_o,
    output logic             pwrite_o,
    output logic             psel_o,
    output logic             penable_o,
    input  logic [WIDTH-1:0] prdata_i,
    input  logic             pready_i
);

    localparam int unsigned CNT_W = 8;
    localparam logic [CNT_W-1:0] TIMEOUT_C = CNT_W'(TIMEOUT);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2,
        RESP   = 2'd3
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [CNT_W-1:0]   r_cnt;
    logic [CNT_W-1:0]   w_cnt_nxt;
    logic [CNT_W-1:0]   w_cnt_inc;

    logic               r_cmd_ready;
    logic               r_rsp_valid;
    logic [WIDTH-1:0]   r_rsp_rdata;
    logic               r_rsp_err;
    logic [WIDTH-1:0]   r_paddr;
    logic [WIDTH-1:0]   r_pwdata;
    logic               r_pwrite;
    logic               r_psel;
    logic               r_penable;

    logic               w_cmd_ready_nxt;
    logic               w_rsp_valid_nxt;
    logic [WIDTH-1:0]   w_rsp_rdata_nxt;
    logic               w_rsp_err_nxt;
    logic [WIDTH-1:0]   w_paddr_nxt;
    logic [WIDTH-1:0]   w_pwdata_nxt;
    logic               w_pwrite_nxt;
    logic               w_psel_nxt;
    logic               w_penable_nxt;

    // State, counter and all registered outputs
    always_ff @(posedge pclk_i or posedge prst_i) begin
        if (prst_i) begin
            r_state     <= IDLE;
            r_cnt       <= '0;
            r_cmd_ready <= 1'b0;
            r_rsp_valid <= 1'b0;
            r_rsp_rdata <= '0;
            r_rsp_err   <= 1'b0;
            r_paddr     <= '0;
            r_pwdata    <= '0;
            r_pwrite    <= 1'b0;
            r_psel      <= 1'b0;
            r_penable   <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_cnt       <= w_cnt_nxt;
            r_cmd_ready <= w_cmd_ready_nxt;
            r_rsp_valid <= w_rsp_valid_nxt;
            r_rsp_rdata <= w_rsp_rdata_nxt;
            r_rsp_err   <= w_rsp_err_nxt;
            r_paddr     <= w_paddr_nxt;
            r_pwdata    <= w_pwdata_nxt;
            r_pwrite    <= w_pwrite_nxt;
            r_psel      <= w_psel_nxt;
            r_penable   <= w_penable_nxt;
        end
    end

    // Next state and next values of the registered outputs
    always_comb begin
        w_state_nxt     = r_state;
        w_cnt_nxt       = r_cnt;
        w_cnt_inc       = r_cnt + CNT_W'(1);
        w_rsp_rdata_nxt = r_rsp_rdata;
        w_rsp_err_nxt   = r_rsp_err;
        w_paddr_nxt     = r_paddr;
        w_pwdata_nxt    = r_pwdata;
        w_pwrite_nxt    = r_pwrite;

        case (r_state)
            IDLE: begin
                // r_cmd_ready is low for the first cycle out of reset
                if (cmd_valid_i && r_cmd_ready) begin
                    w_paddr_nxt  = cmd_addr_i;
                    w_pwdata_nxt = cmd_wdata_i;
                    w_pwrite_nxt = cmd_write_i;
                    w_cnt_nxt    = '0;
                    w_state_nxt  = SETUP;
                end
            end
            SETUP: begin
                w_state_nxt = ACCESS;
            end
            ACCESS: begin
                // pready_i wins over a timeout reached on the same edge
                if (pready_i) begin
                    w_rsp_rdata_nxt = r_pwrite ? '0 : prdata_i;
                    w_rsp_err_nxt   = 1'b0;
                    w_state_nxt     = RESP;
                end else begin
                    w_cnt_nxt = w_cnt_inc;
                    if (w_cnt_inc >= TIMEOUT_C) begin
                        w_rsp_rdata_nxt = '0;
                        w_rsp_err_nxt   = 1'b1;
                        w_state_nxt     = RESP;
                    end
                end
            end
            RESP: begin
                w_state_nxt = IDLE;
            end
        endcase

        // Control outputs are a decode of the state being entered
        w_cmd_ready_nxt = (w_state_nxt == IDLE);
        w_psel_nxt      = (w_state_nxt == SETUP) || (w_state_nxt == ACCESS);
        w_penable_nxt   = (w_state_nxt == ACCESS);
        w_rsp_valid_nxt = (w_state_nxt == RESP);
    end

    assign cmd_ready_o = r_cmd_ready;
    assign rsp_valid_o = r_rsp_valid;
    assign rsp_rdata_o = r_rsp_rdata;
    assign rsp_err_o   = r_rsp_err;
    assign paddr_o     = r_paddr;
    assign pwdata_o    = r_pwdata;
    assign pwrite_o    = r_pwrite;
    assign psel_o      = r_psel;
    assign penable_o   = r_penable;

endmodule

// File: tb/tb_intr_apb_master.sv
// ---------------------------------------------------------------------------
// tb_intr_apb_master
// Self-checking bench: directed vector table, reset-mid-transfer and
// back-to-back sequences, then randomized commands against a memory model.
// ---------------------------------------------------------------------------
module tb_intr_apb_master;

    localparam int unsigned NUM_INTR = 16;
    localparam int unsigned W        = 4;
    localparam int unsigned TMO      = 4;

    logic           pclk_i      = 1'b0;
    logic           prst_i      = 1'b0;
    logic           cmd_valid_i = 1'b0;
    logic           cmd_write_i = 1'b0;
    logic [W-1:0]   cmd_addr_i  = '0;
    logic [W-1:0]   cmd_wdata_i = '0;
    logic [W-1:0]   prdata_i    = '0;
    logic           pready_i    = 1'b0;
    logic           cmd_ready_o;
    logic           rsp_valid_o;
    logic [W-1:0]   rsp_rdata_o;
    logic           rsp_err_o;
    logic [W-1:0]   paddr_o;
    logic [W-1:0]   pwdata_o;
    logic           pwrite_o;
    logic           psel_o;
    logic           penable_o;

    intr_apb_master #(
        .NUM_INTR (NUM_INTR),
        .WIDTH    (W),
        .TIMEOUT  (TMO)
    ) dut (
        .pclk_i      (pclk_i),
        .prst_i      (prst_i),
        .cmd_valid_i (cmd_valid_i),
        .cmd_ready_o (cmd_ready_o),
        .cmd_write_i (cmd_write_i),
        .cmd_addr_i  (cmd_addr_i),
        .cmd_wdata_i (cmd_wdata_i),
        .rsp_valid_o (rsp_valid_o),
        .rsp_rdata_o (rsp_rdata_o),
        .rsp_err_o   (rsp_err_o),
        .paddr_o     (paddr_o),
        .pwdata_o    (pwdata_o),
        .pwrite_o    (pwrite_o),
        .psel_o      (psel_o),
        .penable_o   (penable_o),
        .prdata_i    (prdata_i),
        .pready_i    (pready_i)
    );

    always #5 pclk_i = ~pclk_i;

    int n_cmp  = 0;
    int n_fail = 0;

    // Peripheral register file (updated from the bus) and the reference
    // model's view of it (updated from the commands issued).
    logic [W-1:0] periph_mem [NUM_INTR];
    logic [W-1:0] model_mem  [NUM_INTR];

    typedef struct {
        logic         wr;
        logic [W-1:0] addr;
        logic [W-1:0] wdata;
        int           delay;     // ACCESS cycle with pready_i=1, 0 = never
        logic [W-1:0] exp_rd;
        logic         exp_err;
        int           exp_acc;   // ACCESS cycles expected
    } vec_t;

    vec_t vecs [10];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Bus-side peripheral response for the cycle being sampled
    task automatic periph_cycle(input logic rdy);
        pready_i = rdy;
        prdata_i = periph_mem[paddr_o];
        if (rdy && pwrite_o) periph_mem[paddr_o] = pwdata_o;
    endtask

    // Issue one command and check the whole APB transfer and response
    task automatic do_txn(input logic wr, input logic [W-1:0] a, input logic [W-1:0] d,
                          input int delay, input logic [W-1:0] exp_rd,
                          input logic exp_err, input int exp_acc);
        int  waitc = 0;
        int  acc   = 0;
        bit  got   = 0;
        bit  bad   = 0;
        while (cmd_ready_o !== 1'b1 && waitc < 20) begin
            @(negedge pclk_i);
            waitc++;
        end
        chk("cmd_ready_before", 32'(cmd_ready_o), 1);
        cmd_valid_i = 1'b1;
        cmd_write_i = wr;
        cmd_addr_i  = a;
        cmd_wdata_i = d;
        @(negedge pclk_i);
        cmd_valid_i = 1'b0;
        cmd_write_i = 1'($urandom);
        cmd_addr_i  = W'($urandom);
        cmd_wdata_i = W'($urandom);
        chk("setup_psel",    32'(psel_o), 1);
        chk("setup_penable", 32'(penable_o), 0);
        chk("setup_ready",   32'(cmd_ready_o), 0);
        chk("setup_paddr",   32'(paddr_o), 32'(a));
        chk("setup_pwdata",  32'(pwdata_o), 32'(d));
        chk("setup_pwrite",  32'(pwrite_o), 32'(wr));
        for (int c = 0; c < 40 && !got && !bad; c++) begin
            @(negedge pclk_i);
            pready_i = 1'b0;
            prdata_i = W'($urandom);
            if (rsp_valid_o === 1'b1) begin
                got = 1;
            end else if (psel_o === 1'b1 && penable_o === 1'b1) begin
                acc++;
                chk("access_paddr",  32'(paddr_o), 32'(a));
                chk("access_pwdata", 32'(pwdata_o), 32'(d));
                chk("access_pwrite", 32'(pwrite_o), 32'(wr));
                chk("access_ready",  32'(cmd_ready_o), 0);
                periph_cycle(acc == delay);
            end else begin
                chk("access_psel_pen", {30'd0, psel_o, penable_o}, 32'd3);
                bad = 1;
            end
        end
        pready_i = 1'b0;
        chk("rsp_seen", 32'(got), 1);
        if (got) begin
            chk("rsp_rdata",   32'(rsp_rdata_o), 32'(exp_rd));
            chk("rsp_err",     32'(rsp_err_o), 32'(exp_err));
            chk("access_cnt",  32'(acc), 32'(exp_acc));
            chk("rsp_psel",    {30'd0, psel_o, penable_o}, 0);
            chk("rsp_ready",   32'(cmd_ready_o), 0);
            @(negedge pclk_i);
            chk("post_rsp_valid", 32'(rsp_valid_o), 0);
            chk("post_ready",     32'(cmd_ready_o), 1);
            chk("post_psel",      32'(psel_o), 0);
            chk("hold_rdata",     32'(rsp_rdata_o), 32'(exp_rd));
            chk("hold_err",       32'(rsp_err_o), 32'(exp_err));
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        logic [0:6]   e_psel;
        logic [0:6]   e_pen;
        logic [0:6]   e_rv;
        logic [0:6]   e_rdy;
        logic         r_wr;
        logic [W-1:0] r_a;
        logic [W-1:0] r_d;
        int           r_dl;
        logic         r_err;

        for (int i = 0; i < int'(NUM_INTR); i++) begin
            periph_mem[i] = '0;
            model_mem[i]  = '0;
        end

        //         wr    addr   wdata  dly rdata  err   acc
        vecs[0] = '{1'b1, 4'd3,  4'd9,  2, 4'd0,  1'b0, 2};  // write 3=9, ready in 2nd cycle
        vecs[1] = '{1'b0, 4'd3,  4'd0,  1, 4'd9,  1'b0, 1};  // read back 9, minimum latency
        vecs[2] = '{1'b1, 4'd7,  4'd5,  1, 4'd0,  1'b0, 1};
        vecs[3] = '{1'b0, 4'd7,  4'd2,  4, 4'd5,  1'b0, 4};  // ready on timeout edge wins
        vecs[4] = '{1'b0, 4'd3,  4'd1,  0, 4'd0,  1'b1, 4};  // timeout
        vecs[5] = '{1'b1, 4'd7,  4'd12, 5, 4'd0,  1'b1, 4};  // write times out, no update
        vecs[6] = '{1'b0, 4'd7,  4'd6,  3, 4'd5,  1'b0, 3};
        vecs[7] = '{1'b1, 4'd15, 4'd15, 4, 4'd0,  1'b0, 4};
        vecs[8] = '{1'b0, 4'd15, 4'd8,  1, 4'd15, 1'b0, 1};
        vecs[9] = '{1'b0, 4'd0,  4'd4,  2, 4'd0,  1'b0, 2};

        // Reset
        #1 prst_i = 1'b1;
        #1;
        chk("rst_async_psel", 32'(psel_o), 0);
        @(negedge pclk_i);
        chk("rst_cmd_ready", 32'(cmd_ready_o), 0);
        chk("rst_psel",      32'(psel_o), 0);
        chk("rst_penable",   32'(penable_o), 0);
        chk("rst_pwrite",    32'(pwrite_o), 0);
        chk("rst_paddr",     32'(paddr_o), 0);
        chk("rst_pwdata",    32'(pwdata_o), 0);
        chk("rst_rsp_valid", 32'(rsp_valid_o), 0);
        chk("rst_rdata",     32'(rsp_rdata_o), 0);
        chk("rst_err",       32'(rsp_err_o), 0);
        @(negedge pclk_i);
        prst_i = 1'b0;
        chk("rel_ready_before_edge", 32'(cmd_ready_o), 0);
        @(negedge pclk_i);
        chk("rel_ready_after_edge", 32'(cmd_ready_o), 1);

        // Directed vector table
        for (int i = 0; i < 10; i++) begin
            do_txn(vecs[i].wr, vecs[i].addr, vecs[i].wdata, vecs[i].delay,
                   vecs[i].exp_rd, vecs[i].exp_err, vecs[i].exp_acc);
            if (vecs[i].wr && !vecs[i].exp_err) model_mem[vecs[i].addr] = vecs[i].wdata;
        end

        // Reset asserted mid-ACCESS between clock edges
        cmd_valid_i = 1'b1;
        cmd_write_i = 1'b1;
        cmd_addr_i  = 4'd9;
        cmd_wdata_i = 4'd6;
        @(negedge pclk_i);
        cmd_valid_i = 1'b0;
        chk("rstmid_setup", 32'(psel_o), 1);
        @(negedge pclk_i);
        pready_i = 1'b0;
        chk("rstmid_access1", 32'(penable_o), 1);
        @(negedge pclk_i);
        chk("rstmid_access2", 32'(penable_o), 1);
        #2 prst_i = 1'b1;
        #1;
        chk("rstmid_psel",    32'(psel_o), 0);
        chk("rstmid_penable", 32'(penable_o), 0);
        chk("rstmid_paddr",   32'(paddr_o), 0);
        chk("rstmid_pwrite",  32'(pwrite_o), 0);
        chk("rstmid_ready",   32'(cmd_ready_o), 0);
        for (int k = 0; k < 2; k++) begin
            @(negedge pclk_i);
            chk("rstmid_no_rsp", 32'(rsp_valid_o), 0);
        end
        prst_i = 1'b0;
        @(negedge pclk_i);
        chk("rstmid_no_rsp_rel", 32'(rsp_valid_o), 0);
        chk("rstmid_ready_rel",  32'(cmd_ready_o), 1);
        do_txn(1'b0, 4'd9, 4'd0, 1, model_mem[9], 1'b0, 1);

        // Back-to-back: cmd_valid_i held across two commands
        e_psel = 7'b1100110;
        e_pen  = 7'b0100010;
        e_rv   = 7'b0010001;
        e_rdy  = 7'b0001000;
        pready_i    = 1'b1;
        cmd_valid_i = 1'b1;
        cmd_write_i = 1'b1;
        cmd_addr_i  = 4'd5;
        cmd_wdata_i = 4'd10;
        for (int k = 0; k < 7; k++) begin
            @(negedge pclk_i);
            chk("b2b_psel",    32'(psel_o), 32'(e_psel[k]));
            chk("b2b_penable", 32'(penable_o), 32'(e_pen[k]));
            chk("b2b_rsp_vld", 32'(rsp_valid_o), 32'(e_rv[k]));
            chk("b2b_ready",   32'(cmd_ready_o), 32'(e_rdy[k]));
            if (k < 2) begin
                chk("b2b_a_paddr",  32'(paddr_o), 5);
                chk("b2b_a_pwrite", 32'(pwrite_o), 1);
            end
            if (k == 4 || k == 5) begin
                chk("b2b_b_paddr",  32'(paddr_o), 5);
                chk("b2b_b_pwrite", 32'(pwrite_o), 0);
            end
            if (k == 2) chk("b2b_a_err", 32'(rsp_err_o), 0);
            if (k == 6) begin
                chk("b2b_b_rdata", 32'(rsp_rdata_o), 10);
                chk("b2b_b_err",   32'(rsp_err_o), 0);
            end
            if (k == 0) begin
                cmd_write_i = 1'b0;
                cmd_wdata_i = 4'd3;
            end
            if (k == 4) cmd_valid_i = 1'b0;
            periph_cycle(1'b1);
        end
        pready_i = 1'b0;
        model_mem[5] = 4'd10;
        @(negedge pclk_i);

        // Randomized commands against the memory model
        for (int i = 0; i < 60; i++) begin
            r_wr  = 1'($urandom_range(0, 1));
            r_a   = W'($urandom);
            r_d   = W'($urandom);
            r_dl  = int'($urandom_range(0, 6));
            r_err = (r_dl == 0) || (r_dl > int'(TMO));
            do_txn(r_wr, r_a, r_d, r_dl,
                   (r_err || r_wr) ? W'(0) : model_mem[r_a],
                   r_err, r_err ? int'(TMO) : r_dl);
            if (r_wr && !r_err) model_mem[r_a] = r_d;
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
